serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Sequencing controller for the serial adder datapath: operand/result shift registers, carry flip-flop and bit counter. It accepts a start request and loads operands. It then issues exactly WIDTH shift cycles, holds the result valid until acknowledged, and supports a mid-operation abort. It sits between the host-side request logic and the serial adder datapath.

## Interface
- WIDTH, default 8: operand width in bits; legal range 2..64.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new addition; sampled only in IDLE.
- abort  in  1  cancel an operation; sampled only in LOAD and SHIFT.
- done_ack  in  1  consumer has taken the result; sampled only in DONE.
- ready  out  1  high in IDLE.
- load  out  1  one-cycle pulse; datapath loads operand shift registers.
- carry_clr  out  1  one-cycle pulse coincident with load; clears carry FF to 0.
- shift_en  out  1  high for each bit cycle; datapath shifts one bit and updates carry.
- bit_idx  out  $clog2(WIDTH)  index of the bit being processed while shift_en=1.
- done  out  1  result valid; held high until done_ack.
- aborted  out  1  one-cycle pulse in the first IDLE cycle after an abort.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are Moore decodes of registered state and counter; aborted is a registered flag.
- IDLE: ready=1.
  - start=1 -> LOAD.
  - abort and done_ack are ignored.
- LOAD: load=1, carry_clr=1; bit counter cleared to 0.
  - abort=1 -> IDLE.
  - Otherwise -> SHIFT.
- SHIFT: shift_en=1; bit_idx=counter.
  - abort=1 -> IDLE, with priority over completion.
  - Counter == WIDTH-1 -> DONE.
  - Otherwise counter increments by 1.
- DONE: done=1; counter holds.
  - done_ack=1 -> IDLE.
  - Otherwise stay in DONE.
- Counter:
  - Width $clog2(WIDTH), unsigned.
  - Never wraps in normal operation; terminal value is WIDTH-1, including when WIDTH is a power of two.
  - Holds its value outside SHIFT except for the clear in LOAD.
- start asserted outside IDLE is ignored and not queued.
- Abort semantics:
  - abort takes effect at the next edge. The shift cycle during which abort is sampled still occurs (shift_en=1 that cycle).
  - Datapath contents after an abort are undefined; done is never raised for an aborted operation.
- Simultaneous events:
  - abort on the last SHIFT cycle -> IDLE, not DONE; aborted pulses.
  - start and done_ack held high continuously -> DONE, IDLE, LOAD on consecutive cycles.

## Timing
- Reset values: state IDLE, ready=1, load=0, carry_clr=0, shift_en=0, bit_idx=0, done=0, aborted=0, counter=0.
- Reset mid-operation: all outputs return to reset values asynchronously, without waiting for a clock edge.
- Latency, with start sampled at edge E0:
  - LOAD during cycle 1.
  - SHIFT during cycles 2..WIDTH+1; bit_idx runs 0..WIDTH-1.
  - done=1 from cycle WIDTH+2.
  - Total start-to-done = WIDTH+2 cycles.
- done_ack sampled high at edge Ek -> IDLE (ready=1) in the cycle after Ek. A new start can be sampled at the following edge.
- Minimum issue interval with continuous start and immediate done_ack: WIDTH+3 cycles.
- Abort sampled at edge Ea -> IDLE with aborted=1 for exactly the one cycle after Ea.

## Structure
- Package serial_adder_pkg:
  - State encoding constants: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3.
  - Default WIDTH constant, shared with the datapath so both use one operand width.
- Sub-module serial_bit_counter:
  - Parameter WIDTH.
  - Inputs clk, rst, clr (synchronous), en.
  - Outputs count and last (count==WIDTH-1).
  - Async active-high reset to 0; clr has priority over en.
- Top level: FSM, output decode and aborted flag only.

## Test plan
- Reset: assert rst mid-SHIFT at WIDTH=8 -> outputs immediately ready=1, done=0, shift_en=0, bit_idx=0; a start after release completes normally.
- Nominal, WIDTH=8: start pulse -> load and carry_clr high together for one cycle, then exactly 8 shift_en cycles with bit_idx 0..7, then done=1 at cycle 10 after the start edge.
- Handshake: withhold done_ack for 5 cycles -> done stays high, shift_en stays low; assert done_ack -> ready=1 next cycle. Start held high throughout -> next LOAD begins exactly 11 cycles after the first.
- Abort at bit_idx=3 -> the bit-3 shift still occurs; next cycle IDLE with aborted=1 for one cycle; done never asserts.
- Abort on the last bit (bit_idx=7) -> IDLE, aborted pulses, no done.
- Abort sampled during LOAD -> no shift_en; aborted pulses.
- Ignored inputs: start during SHIFT and DONE, abort during IDLE and DONE, done_ack outside DONE -> no state change. Repeat nominal at WIDTH=5 and WIDTH=16 -> 5 and 16 shift cycles, done at cycles 7 and 18.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and operand width for the serial adder
package serial_adder_pkg;

  // Operand width shared by the controller and the datapath
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// rtl/serial_bit_counter.sv - bit index counter that stops at WIDTH-1
module serial_bit_counter
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] TERM = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  // Clear wins over increment so a LOAD always starts the operation at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign last  = (r_count == TERM);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - sequencing FSM for the serial adder datapath
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     done_ack,
  output logic                     ready,
  output logic                     load,
  output logic                     carry_clr,
  output logic                     shift_en,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     done,
  output logic                     aborted
);

  localparam int CW = $clog2(WIDTH);

  state_t        r_state;
  state_t        w_next;
  logic          r_aborted;
  logic [CW-1:0] w_count;
  logic          w_last;
  logic          w_busy;

  assign w_busy = (r_state == LOAD) || (r_state == SHIFT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort outranks completion on the final shift cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = LOAD;
      LOAD:  w_next = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next = DONE;
        end
      end
      DONE:  if (done_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Aborted flag lands in the first IDLE cycle after a cancelled operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_busy && abort;
    end
  end

  serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_state == LOAD),
    .en   ((r_state == SHIFT) && !w_last),
    .count(w_count),
    .last (w_last)
  );

  assign ready     = (r_state == IDLE);
  assign load      = (r_state == LOAD);
  assign carry_clr = (r_state == LOAD);
  assign shift_en  = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign bit_idx   = w_count;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic done_ack = 1'b0;

  always #5 clk = ~clk;

  logic       rdy8, ld8, cc8, sh8, dn8, ab8;
  logic [2:0] bi8;
  logic       rdy5, ld5, cc5, sh5, dn5, ab5;
  logic [2:0] bi5;
  logic       rdy16, ld16, cc16, sh16, dn16, ab16;
  logic [3:0] bi16;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .done_ack(done_ack),
    .ready(rdy8), .load(ld8), .carry_clr(cc8), .shift_en(sh8), .bit_idx(bi8),
    .done(dn8), .aborted(ab8)
  );

  serial_adder_ctrl #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .done_ack(done_ack),
    .ready(rdy5), .load(ld5), .carry_clr(cc5), .shift_en(sh5), .bit_idx(bi5),
    .done(dn5), .aborted(ab5)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .done_ack(done_ack),
    .ready(rdy16), .load(ld16), .carry_clr(cc16), .shift_en(sh16), .bit_idx(bi16),
    .done(dn16), .aborted(ab16)
  );

  int n_err = 0;
  int n_checks = 0;

  // Timeline model of the WIDTH=8 instance: idle / busy at cycle t after start / holding a result
  int m_mode = 0;
  int m_t = 0;
  bit m_ab = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit s, input bit a, input bit k);
    bit ab_n;
    ab_n = 1'b0;
    case (m_mode)
      0: if (s) begin m_mode = 1; m_t = 1; end
      1: begin
        if (a) begin
          m_mode = 0;
          ab_n = 1'b1;
        end else if (m_t == W8 + 1) begin
          m_mode = 2;
        end else begin
          m_t++;
        end
      end
      default: if (k) m_mode = 0;
    endcase
    m_ab = ab_n;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(start, abort, done_ack);
    @(negedge clk);
    chk("ready", rdy8, m_mode == 0);
    chk("load", ld8, (m_mode == 1) && (m_t == 1));
    chk("carry_clr", cc8, (m_mode == 1) && (m_t == 1));
    chk("shift_en", sh8, (m_mode == 1) && (m_t >= 2));
    chk("done", dn8, m_mode == 2);
    chk("aborted", ab8, m_ab);
    if ((m_mode == 1) && (m_t >= 2)) chk("bit_idx", bi8, m_t - 2);
  endtask

  initial begin
    int n;
    int c8, c5, c16, d8, d5, d16;
    bit found;

    // Reset values
    #1;
    chk("rst_ready", rdy8, 1);
    chk("rst_load", ld8, 0);
    chk("rst_carry_clr", cc8, 0);
    chk("rst_shift_en", sh8, 0);
    chk("rst_bit_idx", bi8, 0);
    chk("rst_done", dn8, 0);
    chk("rst_aborted", ab8, 0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal at widths 8, 5, 16
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("nom_load_w8", ld8 & cc8, 1);
    chk("nom_load_w5", ld5 & cc5, 1);
    chk("nom_load_w16", ld16 & cc16, 1);
    c8 = 0; c5 = 0; c16 = 0; d8 = -1; d5 = -1; d16 = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) cycle();
      c8  += int'(sh8);
      c5  += int'(sh5);
      c16 += int'(sh16);
      if (dn8  && d8  < 0) d8  = i;
      if (dn5  && d5  < 0) d5  = i;
      if (dn16 && d16 < 0) d16 = i;
    end
    chk("nom_shifts_w8", c8, 8);
    chk("nom_shifts_w5", c5, 5);
    chk("nom_shifts_w16", c16, 16);
    chk("nom_done_cycle_w8", d8, 10);
    chk("nom_done_cycle_w5", d5, 7);
    chk("nom_done_cycle_w16", d16, 18);
    done_ack = 1'b1;
    cycle();
    done_ack = 1'b0;
    chk("nom_ready_w5", rdy5, 1);
    chk("nom_ready_w16", rdy16, 1);

    // Handshake with start held high; abort in DONE is ignored
    start = 1'b1;
    cycle();
    chk("hs_load", ld8, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = dn8;
    end
    chk("hs_done_reached", found, 1);
    abort = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hs_done_held", dn8, 1);
      chk("hs_no_shift", sh8, 0);
    end
    abort = 1'b0;
    done_ack = 1'b1;
    cycle();
    chk("hs_ready_after_ack", rdy8, 1);
    cycle();
    chk("hs_reload", ld8, 1);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      n++;
      found = ld8;
    end
    chk("issue_interval", n, 11);
    start = 1'b0;
    done_ack = 1'b0;

    // Abort while in LOAD
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_load_no_shift", sh8, 0);
    chk("abort_load_ready", rdy8, 1);
    chk("abort_load_pulse", ab8, 1);
    cycle();
    chk("abort_load_pulse_end", ab8, 0);

    // Abort at bit 3 and at the last bit
    for (int b = 3; b <= 7; b += 4) begin
      start = 1'b1;
      cycle();
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        cycle();
        found = sh8 && (int'(bi8) == b);
      end
      chk("abort_bit_reached", found, 1);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_bit_ready", rdy8, 1);
      chk("abort_bit_pulse", ab8, 1);
      chk("abort_bit_no_done", dn8, 0);
      cycle();
      chk("abort_bit_pulse_end", ab8, 0);
      chk("abort_bit_no_done_later", dn8, 0);
    end

    // Asynchronous reset in the middle of SHIFT
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("mid_rst_in_shift", sh8, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", rdy8, 1);
    chk("mid_rst_done", dn8, 0);
    chk("mid_rst_shift_en", sh8, 0);
    chk("mid_rst_bit_idx", bi8, 0);
    chk("mid_rst_load", ld8, 0);
    m_mode = 0;
    m_ab = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      n++;
      found = dn8;
    end
    chk("post_rst_done_cycle", n, 10);
    done_ack = 1'b1;
    cycle();
    done_ack = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      start    = ($urandom % 3) == 0;
      abort    = ($urandom % 12) == 0;
      done_ack = ($urandom % 3) == 0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
